// File: rtl/bvashr_cmp_inv_solver_if.sv
// Query/result handshake bundle for bvashr_cmp_inv_solver.
//   slave  : engine side (accepts queries, produces results)
//   master : requester side (issues queries, consumes results)
// Signals:
//   in_valid/in_ready        query handshake; in_s, in_t, in_mode query operands
//   abort                    abandon the scan in progress
//   out_valid/out_ready      result handshake; out_x, out_found, out_iters result
interface bvashr_cmp_inv_solver_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = W + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_s;
  logic [W-1:0]     in_t;
  logic [1:0]       in_mode;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_x;
  logic             out_found;
  logic [CNT_W-1:0] out_iters;

  modport slave (
    input  in_valid, in_s, in_t, in_mode, abort, out_ready,
    output in_ready, out_valid, out_x, out_found, out_iters
  );

  modport master (
    output in_valid, in_s, in_t, in_mode, abort, out_ready,
    input  in_ready, out_valid, out_x, out_found, out_iters
  );
endinterface

// File: rtl/bvashr_cmp_inv_solver.sv
// Sequential witness search for "find x with cmp(x >>a s, t)", cmp one of
// SLE/SLT/SGE/SGT (in_mode 0..3). Scans all 2^W candidates starting at a seed and
// reports the first one satisfying the predicate, or found=0 if none exists.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   bus         slave side of bvashr_cmp_inv_solver_if (query, abort, result)
// Build option:
//   SKOLEM_EXTREMAL_SEED_EN  seed with signed MIN (SLE/SLT) or signed MAX (SGE/SGT)
//                            so the closed-form witness is tried first; otherwise
//                            the scan starts at 0.
module bvashr_cmp_inv_solver #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = W + 1
) (
  input logic                   clk,
  input logic                   rst_n,
  bvashr_cmp_inv_solver_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [W-1:0]     ShLimit = W'(W);
  localparam logic [W-1:0]     MinVal  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     MaxVal  = ~MinVal;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'((1 << W) - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(1 << W);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     s_q, s_d;
  logic [W-1:0]     t_q, t_d;
  logic [1:0]       mode_q, mode_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     x_q, x_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] iters_q, iters_d;

  logic [W-1:0]        seed;
  logic signed [W-1:0] shifted;
  logic                pred;

  always_comb begin
`ifdef SKOLEM_EXTREMAL_SEED_EN
    // SGE/SGT have mode bit 1 set; the extremal value is the canonical witness.
    seed = bus.in_mode[1] ? MaxVal : MinVal;
`else
    seed = '0;
`endif
  end

  // Shift amounts of W or more saturate to all sign bits.
  always_comb begin
    if (s_q >= ShLimit) begin
      shifted = {W{cand_q[W-1]}};
    end else begin
      shifted = $signed(cand_q) >>> s_q;
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    pred = (shifted <= $signed(t_q));
      2'd1:    pred = (shifted <  $signed(t_q));
      2'd2:    pred = (shifted >= $signed(t_q));
      default: pred = (shifted >  $signed(t_q));
    endcase
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    mode_d  = mode_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    x_d     = x_q;
    found_d = found_q;
    iters_d = iters_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          s_d     = bus.in_s;
          t_d     = bus.in_t;
          mode_d  = bus.in_mode;
          cand_d  = seed;
          cnt_d   = '0;
          state_d = StEval;
        end
      end
      StEval: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (pred) begin
          x_d     = cand_q;
          found_d = 1'b1;
          iters_d = cnt_q + CNT_W'(1);
          state_d = StDone;
        end else if (cnt_q == LastCnt) begin
          x_d     = '0;
          found_d = 1'b0;
          iters_d = FullCnt;
          state_d = StDone;
        end else begin
          cand_d = cand_q + W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        // First DONE cycle publishes the registered result; out_valid follows.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      t_q     <= '0;
      mode_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      found_q <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      found_q <= found_d;
      iters_q <= iters_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = valid_q;
  assign bus.out_x     = x_q;
  assign bus.out_found = found_q;
  assign bus.out_iters = iters_q;

endmodule

// File: tb/tb_bvashr_cmp_inv_solver.sv
// Randomised self-checking bench for bvashr_cmp_inv_solver (W=4) with a brute-force
// arithmetic reference model and a few hand-computed literal expectations.
module tb_bvashr_cmp_inv_solver;
  localparam int W     = 4;
  localparam int CNT_W = W + 1;
  localparam int N     = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bvashr_cmp_inv_solver_if #(.W(W)) bus ();

  bvashr_cmp_inv_solver #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: try seed, seed+1, ... using signed integer floor division for ashr.
  function automatic void model(input logic [W-1:0] s, input logic [W-1:0] t,
                                input logic [1:0] m, output logic [W-1:0] x,
                                output logic f, output int iters);
    int seed, tv, d, c, cv, sh;
    bit p;
`ifdef SKOLEM_EXTREMAL_SEED_EN
    seed = (m >= 2) ? (N / 2 - 1) : (N / 2);
`else
    seed = 0;
`endif
    tv = (int'(t) >= N / 2) ? int'(t) - N : int'(t);
    d  = 1 << s;
    x = '0; f = 1'b0; iters = N;
    for (int j = 0; j < N; j++) begin
      c  = (seed + j) % N;
      cv = (c >= N / 2) ? c - N : c;
      sh = (cv >= 0) ? cv / d : -((-cv + d - 1) / d);
      case (m)
        2'd0:    p = (sh <= tv);
        2'd1:    p = (sh <  tv);
        2'd2:    p = (sh >= tv);
        default: p = (sh >  tv);
      endcase
      if (p) begin
        x = W'(c); f = 1'b1; iters = j + 1;
        return;
      end
    end
  endfunction

  logic            exp_armed = 1'b0;
  logic [W-1:0]    exp_x;
  logic            exp_found;
  int              exp_iters;

  // Whenever a result is presented it must match the model and hold steady.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (!exp_armed) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_x", bus.out_x, exp_x);
        chk("out_found", bus.out_found, exp_found);
        chk("out_iters", bus.out_iters, exp_iters);
        chk("in_ready_in_done", bus.in_ready, 0);
      end
    end
  end

  logic [W-1:0] got_x;
  logic         got_found;
  int           got_iters;
  int           got_lat;

  task automatic query(input logic [W-1:0] s, input logic [W-1:0] t,
                       input logic [1:0] m, input int hold);
    logic [W-1:0] ex;
    logic ef;
    int ei;
    int lat;
    model(s, t, m, ex, ef, ei);
    @(negedge clk);
    exp_x = ex; exp_found = ef; exp_iters = ei; exp_armed = 1'b1;
    bus.in_s = s; bus.in_t = t; bus.in_mode = m;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_accept", bus.in_ready, 0);
    // Operands must be ignored after the accept.
    bus.in_valid = 1'b0;
    bus.in_s = W'($urandom); bus.in_t = W'($urandom); bus.in_mode = 2'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < N + 5) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, ei + 1);
    got_x = bus.out_x; got_found = bus.out_found; got_iters = int'(bus.out_iters);
    got_lat = lat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.abort = 1'($urandom);
      bus.out_ready = 1'b0;
    end
    @(negedge clk);
    bus.abort = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_handshake", bus.out_valid, 0);
    chk("in_ready_after_handshake", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    exp_armed = 1'b0;
  endtask

  // Start the no-solution scan, then kill it at scan cycle 3 by abort or reset.
  task automatic interrupt(input bit use_reset);
    logic [W-1:0] px;
    logic pf;
    logic [31:0] pi;
    px = bus.out_x; pf = bus.out_found; pi = 32'(bus.out_iters);
    @(negedge clk);
    exp_armed = 1'b0;
    bus.in_s = 4'd1; bus.in_t = 4'b1000; bus.in_mode = 2'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else bus.abort = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.abort = 1'b0;
    chk(use_reset ? "rst_in_ready" : "abort_in_ready", bus.in_ready, 1);
    chk(use_reset ? "rst_out_valid" : "abort_out_valid", bus.out_valid, 0);
    chk(use_reset ? "rst_out_x" : "abort_out_x", bus.out_x, use_reset ? 0 : px);
    chk(use_reset ? "rst_found" : "abort_found", bus.out_found, use_reset ? 0 : pf);
    chk(use_reset ? "rst_iters" : "abort_iters", bus.out_iters, use_reset ? 0 : pi);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] mx;
    logic mf;
    int mi;
    bus.in_valid = 1'b0; bus.in_s = '0; bus.in_t = '0; bus.in_mode = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_x", bus.out_x, 0);
    chk("reset_out_found", bus.out_found, 0);
    chk("reset_out_iters", bus.out_iters, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model on hand-derived cases.
    model(4'd0, 4'b1000, 2'd0, mx, mf, mi);
    chk("model_case2_x", mx, 4'b1000);
`ifdef SKOLEM_EXTREMAL_SEED_EN
    chk("model_case2_iters", mi, 1);
`else
    chk("model_case2_iters", mi, 9);
`endif
    model(4'd1, 4'b1000, 2'd0, mx, mf, mi);
    chk("model_case3_found", mf, 0);
    chk("model_case3_iters", mi, 16);

    // Case 1, held in DONE for 5 cycles.
    query(4'd1, 4'd0, 2'd0, 5);
    chk("case1_found", got_found, 1);
    chk("case1_lat", got_lat, 2);
`ifdef SKOLEM_EXTREMAL_SEED_EN
    chk("case1_x", got_x, 4'b1000);
`else
    chk("case1_x", got_x, 0);
`endif
    chk("case1_iters", got_iters, 1);

    query(4'd0, 4'b1000, 2'd0, 1);
    chk("case2_x", got_x, 4'b1000);
`ifdef SKOLEM_EXTREMAL_SEED_EN
    chk("case2_iters", got_iters, 1);
`else
    chk("case2_iters", got_iters, 9);
`endif

    query(4'd1, 4'b1000, 2'd0, 0);
    chk("case3_found", got_found, 0);
    chk("case3_x", got_x, 0);
    chk("case3_iters", got_iters, 16);
    chk("case3_lat", got_lat, 17);

    query(4'd4, 4'b1111, 2'd1, 2);
    chk("case4_slt_found", got_found, 0);
    chk("case4_slt_iters", got_iters, 16);

    query(4'd4, 4'b1111, 2'd3, 0);
    chk("case4_sgt_found", got_found, 1);
    chk("case4_sgt_iters", got_iters, 1);
`ifdef SKOLEM_EXTREMAL_SEED_EN
    chk("case4_sgt_x", got_x, 4'b0111);
`else
    chk("case4_sgt_x", got_x, 0);
`endif

    interrupt(1'b0);
    query(4'd2, 4'd1, 2'd2, 1);
    interrupt(1'b1);
    query(4'd0, 4'd7, 2'd3, 0);
    chk("sgt_max_none_found", got_found, 0);

    for (int n = 0; n < 40; n++) begin
      query(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
